test_supervisor: RTL and testbench
==================================

Name: test_supervisor

Overview:
Synthesizable, parametrised successor to the simulation test driver. It sequences DUT reset and tracks up to NUM_CH independent success/failure channels. It enforces a programmable cycle timeout and a heartbeat stall watchdog, and reports a single sticky pass/fail verdict with a reason code. It sits between the test harness top and the DUT so the same end-of-test logic works in simulation, emulation and on silicon debug.

Parameters:
NUM_CH, 4, number of success/failure channels (>=1)
CYCLE_W, 64, width of cycle counter and max_cycles
RESET_CYCLES, 16, cycles dut_reset is held after reset release (>=1)
STALL_W, 16, width of stall counter and stall_limit
REQUIRE_ALL, 1, 1 = pass needs success from every enabled channel; 0 = any enabled channel

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
max_cycles  in  CYCLE_W  timeout limit; 0 disables the timeout; quasi-static
stall_limit  in  STALL_W  heartbeat watchdog limit; 0 disables the watchdog; quasi-static
ch_enable  in  NUM_CH  per-channel enable; quasi-static
ch_success  in  NUM_CH  per-channel success pulse or level
ch_failure  in  NUM_CH  per-channel failure pulse or level
heartbeat  in  1  DUT progress strobe
dut_reset  out  1  reset driven to the DUT
running  out  1  high in RUN state
done  out  1  verdict reached (sticky)
pass  out  1  test passed (sticky)
fail  out  1  test failed (sticky)
fail_reason  out  2  0 none, 1 channel failure, 2 timeout, 3 stall
fail_channel  out  $clog2(NUM_CH) or 1  lowest-index failing channel; valid when fail_reason==1
cycle_count  out  CYCLE_W  RUN cycles elapsed
success_seen  out  NUM_CH  sticky per-channel success flags

Behaviour:
- Single clock domain. Reset is asynchronous, active-high.
- Reset values: state=HOLD, dut_reset=1, running=0, done=0, pass=0, fail=0, fail_reason=0, fail_channel=0, cycle_count=0, success_seen=0, internal hold counter=0, internal stall counter=0.
- FSM states: HOLD, RUN, PASS, FAIL.
- HOLD: the hold counter increments each cycle. When it reaches RESET_CYCLES-1, go to RUN. dut_reset is low from the first RUN cycle, so dut_reset is high for exactly RESET_CYCLES cycles after reset falls. All channel and heartbeat inputs are ignored in HOLD.
- RUN, per cycle:
  - running=1.
  - cycle_count increments and saturates at all-ones.
  - success_seen |= ch_success & ch_enable.
  - Stall counter clears on heartbeat; otherwise it increments and saturates.
- Terminal checks, evaluated on registered state plus current inputs. Priority when events coincide: failure > timeout > stall > pass.
  - Failure: any (ch_failure & ch_enable) -> FAIL, reason 1, fail_channel = lowest set index.
  - Timeout: max_cycles!=0 and cycle_count+1 == max_cycles -> FAIL, reason 2. The test gets exactly max_cycles RUN cycles.
  - Stall: stall_limit!=0, heartbeat low, and stall counter+1 == stall_limit -> FAIL, reason 3.
  - Pass: success term = success_seen | (ch_success & ch_enable), i.e. the same-cycle success counts.
    - REQUIRE_ALL=1: pass when the success term equals ch_enable and ch_enable!=0.
    - REQUIRE_ALL=0: pass when the success term is nonzero.
    - ch_enable==0 never passes; the test can only time out or stall.
- Verdict outputs (done/pass/fail/fail_reason/fail_channel) are registered and appear the cycle after the triggering input. The cycle_count value on that cycle includes the final RUN cycle.
- PASS/FAIL are absorbing states:
  - done=1; pass xor fail; running=0.
  - cycle_count and success_seen freeze.
  - dut_reset stays 0 so DUT state remains inspectable.
  - Only reset leaves these states.
- Reset asserted mid-RUN or in a terminal state returns everything to reset values immediately (asynchronous), and the hold sequence restarts on release.
- Inputs changing during RUN are not required to be handled sensibly except ch_success, ch_failure and heartbeat.

Decomposition:
- Package test_supervisor_pkg:
  - state enum {HOLD, RUN, PASS, FAIL}
  - fail_reason constants REASON_NONE=0, REASON_CHAN=1, REASON_TIMEOUT=2, REASON_STALL=3
- Sub-module sat_counter (parametrised width; clear, enable, saturating). Instantiated for cycle_count, the stall counter and the hold counter.
- Lowest-index priority encoder is a function in the package.

Test Plan:
- Reset release, NUM_CH=4, ch_enable=4'b1111, no activity -> dut_reset high exactly 16 cycles, then running=1, cycle_count=0 on the first RUN cycle.
- ch_success pulses on ch0..ch3 at RUN cycles 5, 9, 9, 20 -> success_seen builds up, done=pass=1 one cycle after cycle 20, cycle_count=21, fail=0.
- max_cycles=100, no success -> fail=1, reason=2, cycle_count=100. A repeat with max_cycles=0 never times out over 10000 cycles.
- stall_limit=8, heartbeat every 7 cycles, then stopped after RUN cycle 30 -> no fail while pulsing; reason=3 one cycle after the 8th idle cycle.
- Same cycle: ch_failure[2], ch_failure[1], and the final ch_success -> fail=1, reason=1, fail_channel=1, pass=0. Repeat with ch_enable[1]=0 -> fail_channel=2.
- Assert reset in FAIL state mid-cycle -> all outputs return to reset values asynchronously and the 16-cycle hold restarts. Also run REQUIRE_ALL=0 with ch_enable=0 -> never passes, reason=2 at timeout.

Source files
------------

// File: rtl/test_supervisor_pkg.sv
// test_supervisor_pkg: shared state encoding, verdict reason codes and channel priority encoder
package test_supervisor_pkg;

   typedef enum logic [1:0] {HOLD, RUN, PASS, FAIL} state_t;

   localparam logic [1:0] REASON_NONE    = 2'd0;
   localparam logic [1:0] REASON_CHAN    = 2'd1;
   localparam logic [1:0] REASON_TIMEOUT = 2'd2;
   localparam logic [1:0] REASON_STALL   = 2'd3;

   function automatic logic [5:0] lowest_index(input logic [63:0] v);
      lowest_index = '0;
      for (int i = 63; i >= 0; i--) lowest_index = v[i] ? 6'(i) : lowest_index;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter with synchronous clear that holds at all-ones
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   // clear wins over enable; counting stops once every bit is set
   always_ff @(posedge clock or posedge reset)
      if (reset) count <= '0;
      else if (clear) count <= '0;
      else if (enable && count != '1) count <= count + W'(1);

endmodule

// File: rtl/test_supervisor.sv
// test_supervisor: sequences DUT reset, tracks channel results and latches a sticky pass/fail verdict
module test_supervisor
   import test_supervisor_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CYCLE_W = 64,
   parameter int RESET_CYCLES = 16,
   parameter int STALL_W = 16,
   parameter int REQUIRE_ALL = 1,
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [CYCLE_W-1:0] max_cycles,
   input  logic [STALL_W-1:0] stall_limit,
   input  logic [NUM_CH-1:0]  ch_enable,
   input  logic [NUM_CH-1:0]  ch_success,
   input  logic [NUM_CH-1:0]  ch_failure,
   input  logic               heartbeat,
   output logic               dut_reset,
   output logic               running,
   output logic               done,
   output logic               pass,
   output logic               fail,
   output logic [1:0]         fail_reason,
   output logic [CH_W-1:0]    fail_channel,
   output logic [CYCLE_W-1:0] cycle_count,
   output logic [NUM_CH-1:0]  success_seen
);

   localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

   state_t             state;
   logic [HOLD_W-1:0]  hold_count;
   logic [STALL_W-1:0] stall_count;
   logic [NUM_CH-1:0]  fail_vec, success_term;
   logic               in_run, timeout, stall, pass_ok;

   assign in_run = state == RUN;

   sat_counter #(.W(HOLD_W)) u_hold (
      .clock(clock), .reset(reset), .clear(1'b0), .enable(state == HOLD), .count(hold_count)
   );

   sat_counter #(.W(CYCLE_W)) u_cycle (
      .clock(clock), .reset(reset), .clear(1'b0), .enable(in_run), .count(cycle_count)
   );

   sat_counter #(.W(STALL_W)) u_stall (
      .clock(clock), .reset(reset), .clear(in_run && heartbeat), .enable(in_run), .count(stall_count)
   );

   // terminal conditions seen from this cycle's registered state plus live inputs
   always_comb begin
      fail_vec = ch_failure & ch_enable;
      success_term = success_seen | (ch_success & ch_enable);
      timeout = max_cycles != '0 && cycle_count + CYCLE_W'(1) == max_cycles;
      stall = stall_limit != '0 && !heartbeat && stall_count + STALL_W'(1) == stall_limit;
      pass_ok = REQUIRE_ALL != 0 ? success_term == ch_enable && ch_enable != '0 : success_term != '0;
   end

   // supervisor FSM: hold DUT in reset, run, then latch the first verdict by priority
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= HOLD;
         dut_reset <= 1'b1;
         running <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         fail <= 1'b0;
         fail_reason <= REASON_NONE;
         fail_channel <= '0;
         success_seen <= '0;
      end else begin
         case (state)
            HOLD:
               if (hold_count == HOLD_W'(RESET_CYCLES - 1)) begin
                  state <= RUN;
                  dut_reset <= 1'b0;
                  running <= 1'b1;
               end
            RUN: begin
               success_seen <= success_term;
               if (fail_vec != '0 || timeout || stall) begin
                  state <= FAIL;
                  running <= 1'b0;
                  done <= 1'b1;
                  fail <= 1'b1;
                  fail_reason <= fail_vec != '0 ? REASON_CHAN : timeout ? REASON_TIMEOUT : REASON_STALL;
                  fail_channel <= CH_W'(lowest_index(64'(fail_vec)));
               end else if (pass_ok) begin
                  state <= PASS;
                  running <= 1'b0;
                  done <= 1'b1;
                  pass <= 1'b1;
               end
            end
            default: ;
         endcase
      end

endmodule

// File: tb/tb_test_supervisor.sv
// tb_test_supervisor: random and directed scenarios against a run-length reference model, both REQUIRE_ALL settings
module tb_test_supervisor;

   localparam int N = 4;
   localparam int CW = 64;
   localparam int SW = 16;
   localparam int RC = 16;
   localparam int LMAX = 10100;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [CW-1:0] max_cycles = '0;
   logic [SW-1:0] stall_limit = '0;
   logic [N-1:0] ch_enable = '0, ch_success = '0, ch_failure = '0;
   logic heartbeat = 1'b0;

   logic [1:0] dr, run_o, dn, ps, fl;
   logic [1:0][1:0] rsn, fch;
   logic [1:0][CW-1:0] cyc;
   logic [1:0][N-1:0] seen_o;

   logic [N-1:0] s_a [LMAX];
   logic [N-1:0] f_a [LMAX];
   logic hb_a [LMAX];

   int vc [2];
   int rs [2];
   int chn [2];
   logic [N-1:0] sv [2];

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      test_supervisor #(
         .NUM_CH(N), .CYCLE_W(CW), .RESET_CYCLES(RC), .STALL_W(SW), .REQUIRE_ALL(g == 0 ? 1 : 0)
      ) dut (
         .clock(clock), .reset(reset), .max_cycles(max_cycles), .stall_limit(stall_limit),
         .ch_enable(ch_enable), .ch_success(ch_success), .ch_failure(ch_failure), .heartbeat(heartbeat),
         .dut_reset(dr[g]), .running(run_o[g]), .done(dn[g]), .pass(ps[g]), .fail(fl[g]),
         .fail_reason(rsn[g]), .fail_channel(fch[g]), .cycle_count(cyc[g]), .success_seen(seen_o[g])
      );
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Walk RUN cycles applying the verdict rules directly: idle run length stands in for the stall counter.
   function automatic void model(input int req_all, input int len, output int v, output int r,
                                 output int c, output logic [N-1:0] seen);
      int last_hb;
      v = -1;
      r = 0;
      c = 0;
      seen = '0;
      last_hb = -1;
      for (int n = 0; n < len; n++) begin
         logic [N-1:0] s, f;
         int idle;
         s = s_a[n] & ch_enable;
         f = f_a[n] & ch_enable;
         seen = seen | s;
         idle = hb_a[n] ? 0 : n - last_hb;
         if (hb_a[n]) last_hb = n;
         if (f != '0) begin
            r = 1;
            for (int i = N - 1; i >= 0; i--) if (f[i]) c = i;
            v = n;
            return;
         end
         if (max_cycles != '0 && 64'(n + 1) == max_cycles) begin
            r = 2;
            v = n;
            return;
         end
         if (stall_limit != '0 && !hb_a[n] && idle == int'(stall_limit)) begin
            r = 3;
            v = n;
            return;
         end
         if (req_all != 0 ? (ch_enable != '0 && (seen & ch_enable) == ch_enable) : seen != '0) begin
            r = 0;
            v = n;
            return;
         end
      end
   endfunction

   task automatic fill(input int p_s, input int p_f, input int p_hb);
      for (int n = 0; n < LMAX; n++) begin
         for (int i = 0; i < N; i++) begin
            s_a[n][i] = p_s > 0 && $urandom_range(0, p_s - 1) == 0;
            f_a[n][i] = p_f > 0 && $urandom_range(0, p_f - 1) == 0;
         end
         hb_a[n] = p_hb > 0 && $urandom_range(0, p_hb - 1) == 0;
      end
   endtask

   task automatic check_dut(input string name, input int g, input int k);
      string p;
      p = $sformatf("%s d%0d k%0d", name, g, k);
      check({p, " dut_reset"}, 64'(dr[g]), 64'(0));
      if (k == 0) check({p, " seen_hold"}, 64'(seen_o[g]), 64'(0));
      if (vc[g] < 0 || k <= vc[g]) begin
         check({p, " running"}, 64'(run_o[g]), 64'(1));
         check({p, " done"}, 64'(dn[g]), 64'(0));
         check({p, " cycle"}, cyc[g], 64'(k));
      end else begin
         check({p, " running"}, 64'(run_o[g]), 64'(0));
         check({p, " done"}, 64'(dn[g]), 64'(1));
         check({p, " pass"}, 64'(ps[g]), 64'(rs[g] == 0));
         check({p, " fail"}, 64'(fl[g]), 64'(rs[g] != 0));
         check({p, " reason"}, 64'(rsn[g]), 64'(rs[g]));
         if (rs[g] == 1) check({p, " channel"}, 64'(fch[g]), 64'(chn[g]));
         check({p, " cycle"}, cyc[g], 64'(vc[g] + 1));
         check({p, " seen"}, 64'(seen_o[g]), 64'(sv[g]));
      end
   endtask

   task automatic run_test(input string name, input int len);
      int cnt, kend;
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         check({name, " rst dut_reset"}, 64'(dr[g]), 64'(1));
         check({name, " rst running"}, 64'(run_o[g]), 64'(0));
         check({name, " rst done"}, 64'(dn[g]), 64'(0));
         check({name, " rst pass"}, 64'(ps[g]), 64'(0));
         check({name, " rst fail"}, 64'(fl[g]), 64'(0));
         check({name, " rst reason"}, 64'(rsn[g]), 64'(0));
         check({name, " rst channel"}, 64'(fch[g]), 64'(0));
         check({name, " rst cycle"}, cyc[g], 64'(0));
         check({name, " rst seen"}, 64'(seen_o[g]), 64'(0));
      end
      for (int g = 0; g < 2; g++) model(g == 0 ? 1 : 0, len, vc[g], rs[g], chn[g], sv[g]);
      @(negedge clock);
      reset = 1'b0;
      cnt = 0;
      while (dr[0] && cnt < 40) begin
         cnt++;
         ch_success = N'($urandom);
         ch_failure = N'($urandom);
         heartbeat = 1'($urandom);
         @(negedge clock);
      end
      check({name, " hold_len"}, 64'(cnt), 64'(RC));
      kend = (vc[0] > vc[1] ? vc[0] : vc[1]) + 3;
      if (vc[0] < 0 || vc[1] < 0 || kend > len) kend = len;
      for (int k = 0; k <= kend; k++) begin
         for (int g = 0; g < 2; g++) check_dut(name, g, k);
         ch_success = s_a[k];
         ch_failure = f_a[k];
         heartbeat = hb_a[k];
         @(negedge clock);
      end
   endtask

   initial begin
      ch_enable = 4'hF;
      fill(0, 0, 2);
      s_a[5][0] = 1'b1;
      s_a[9][1] = 1'b1;
      s_a[9][2] = 1'b1;
      s_a[20][3] = 1'b1;
      run_test("succ", 200);

      fill(0, 0, 2);
      max_cycles = 100;
      run_test("tmo", 300);

      max_cycles = 0;
      run_test("notmo", 10000);

      stall_limit = 8;
      fill(0, 0, 0);
      for (int n = 0; n <= 28; n += 7) hb_a[n] = 1'b1;
      run_test("stall", 100);

      stall_limit = 0;
      fill(0, 0, 2);
      s_a[3] = 4'b1001;
      s_a[6] = 4'b0010;
      s_a[12] = 4'b0100;
      f_a[12] = 4'b0110;
      run_test("prio", 100);
      ch_enable = 4'b1101;
      run_test("prio_en", 100);

      ch_enable = 4'b0000;
      max_cycles = 50;
      fill(3, 5, 2);
      run_test("noen", 100);

      for (int t = 0; t < 10; t++) begin
         ch_enable = N'($urandom_range(0, 15));
         max_cycles = $urandom_range(0, 2) == 0 ? 64'(0) : 64'($urandom_range(10, 150));
         stall_limit = $urandom_range(0, 1) == 0 ? SW'(0) : SW'($urandom_range(3, 12));
         fill(12, 80, 3);
         run_test($sformatf("rnd%0d", t), 400);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
